// File: rtl/adder_arbiter_if.sv
// Requester-side bus of adder_arbiter: per-requester operand requests and the shared result.
interface adder_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_z;
    logic [NREQ-1:0]      rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z
    );
endinterface

// File: rtl/adder_arbiter.sv
// Shares one strobe/ack handshaked adder between NREQ requesters, one operation at a time.
// Round-robin by default; define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic              clk,
    input  logic              rst,
    adder_arbiter_if.slave    bus,
    output logic [31:0]       add_a,
    output logic              add_a_stb,
    input  logic              add_a_ack,
    output logic [31:0]       add_b,
    output logic              add_b_stb,
    input  logic              add_b_ack,
    input  logic [31:0]       add_z,
    input  logic              add_z_stb,
    output logic              add_z_ack,
    output logic              busy,
    output logic [IDXW-1:0]   owner,
    output logic [15:0]       op_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] grant_idx;
    logic [IDXW-1:0] pos;
    logic            grant_found;

    // First valid requester found when searching upward from the search start, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            pos = IDXW'(k);
`else
            pos = IDXW'((int'(ptr) + k) % NREQ);
`endif
            if (!grant_found && bus.req_valid[pos]) begin
                grant_found = 1'b1;
                grant_idx   = pos;
            end
        end
    end

    // Gated by rst so nothing is ever accepted while the block is held in reset.
    assign bus.req_ready = (state == IDLE && grant_found && !rst) ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            op_count      <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_a_stb     <= 1'b0;
            add_b_stb     <= 1'b0;
            add_z_ack     <= 1'b0;
            busy          <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_z     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        add_a     <= bus.req_a[32*int'(grant_idx) +: 32];
                        add_b     <= bus.req_b[32*int'(grant_idx) +: 32];
                        owner     <= grant_idx;
`ifdef ADDER_ARB_FIXED_PRIO_EN
                        ptr       <= '0;
`else
                        ptr       <= IDXW'((int'(grant_idx) + 1) % NREQ);
`endif
                        add_a_stb <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (add_a_stb && add_a_ack) begin
                        add_a_stb <= 1'b0;
                        add_b_stb <= 1'b1;
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (add_b_stb && add_b_ack) begin
                        add_b_stb <= 1'b0;
                        add_z_ack <= 1'b1;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (add_z_stb && add_z_ack) begin
                        bus.rsp_z     <= add_z;
                        add_z_ack     <= 1'b0;
                        bus.rsp_valid <= NREQ'(1) << owner;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        bus.rsp_valid <= '0;
                        op_count      <= op_count + 16'd1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with a stand-in handshaked adder.
// Honours ADDER_ARB_FIXED_PRIO_EN when choosing the expected arbitration order.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     add_a, add_b, add_z;
    logic            add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
    logic            busy;
    logic [IDXW-1:0] owner;
    logic [15:0]     op_count;

    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    logic [31:0] z_result   = 32'h0;
    int          z_lat      = 0;
    logic [31:0] a_seen     = 32'h0;
    logic [31:0] b_seen     = 32'h0;
    logic [15:0] exp_ops    = 16'h0;

    adder_arbiter_if #(.NREQ(NREQ)) bus ();

    adder_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .add_a     (add_a),
        .add_a_stb (add_a_stb),
        .add_a_ack (add_a_ack),
        .add_b     (add_b),
        .add_b_stb (add_b_stb),
        .add_b_ack (add_b_ack),
        .add_z     (add_z),
        .add_z_stb (add_z_stb),
        .add_z_ack (add_z_ack),
        .busy      (busy),
        .owner     (owner),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Stand-in adder: acks A early (before the strobe), then B, then returns z_result after z_lat cycles.
    initial begin : mock_adder
        int mstate;
        int wait_left;
        mstate    = 0;
        wait_left = 0;
        add_a_ack = 1'b0;
        add_b_ack = 1'b0;
        add_z_stb = 1'b0;
        add_z     = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mstate    = 0;
                add_a_ack = 1'b0;
                add_b_ack = 1'b0;
                add_z_stb = 1'b0;
                add_z     = 32'h0;
            end else begin
                case (mstate)
                    0: begin
                        add_a_ack = 1'b1;
                        if (add_a_stb) begin
                            a_seen = add_a;
                            mstate = 1;
                        end
                    end
                    1: begin
                        add_a_ack = 1'b0;
                        add_b_ack = 1'b1;
                        if (add_b_stb) begin
                            b_seen    = add_b;
                            wait_left = z_lat;
                            mstate    = 2;
                        end
                    end
                    2: begin
                        add_b_ack = 1'b0;
                        if (wait_left > 0) begin
                            wait_left--;
                        end else begin
                            add_z     = z_result;
                            add_z_stb = 1'b1;
                            if (add_z_ack) mstate = 3;
                        end
                    end
                    default: begin
                        add_z_stb = 1'b0;
                        mstate    = 0;
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic waitResponse(input int budget, output int cycles, output logic ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (bus.rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete transaction from requester idx with all rsp_ready high; lat is acceptance-to-rsp_valid cycles.
    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] z, output int lat);
        int   cyc;
        logic ok;
        @(negedge clk);
        z_result                   = z;
        bus.req_a[32*idx +: 32]    = a;
        bus.req_b[32*idx +: 32]    = b;
        bus.req_valid              = NREQ'(1) << idx;
        #1;
        checkOutput("req_ready_grant", 32'(bus.req_ready), 32'(NREQ'(1) << idx));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        waitResponse(60, cyc, ok);
        checkOutput("rsp_timeout", 32'(ok), 32'h1);
        lat = cyc - 1;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(NREQ'(1) << idx));
        checkOutput("rsp_z", bus.rsp_z, z);
        checkOutput("owner", 32'(owner), 32'(idx));
        @(negedge clk);
        exp_ops++;
        checkOutput("op_count", 32'(op_count), 32'(exp_ops));
        checkOutput("busy_after", 32'(busy), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int          lat;
        int          cyc;
        logic        ok;
        int          exp_owner;
        logic [31:0] held_z;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;

        // Reset state, with every requester asking so req_ready gating is exercised.
        bus.req_valid = '1;
        @(negedge clk);
        checkOutput("rst_busy",      32'(busy),          32'h0);
        checkOutput("rst_owner",     32'(owner),         32'h0);
        checkOutput("rst_op_count",  32'(op_count),      32'h0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_rsp_z",     bus.rsp_z,          32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_strobes",   32'({add_a_stb, add_b_stb, add_z_ack}), 32'h0);
        bus.req_valid = '0;
        rst = 1'b0;

        // 1.0 + 2.0 = 3.0 in IEEE-754 single precision.
        $display("[TB] single request");
        applyStimulus(0, 32'h3F800000, 32'h40000000, 32'h40400000, lat);
        checkOutput("single_a_seen", a_seen, 32'h3F800000);
        checkOutput("single_b_seen", b_seen, 32'h40000000);
        checkOutput("single_latency", 32'(lat), 32'd3);

        // All requesters held high straight out of reset.
        $display("[TB] arbitration order");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = {8'(i + 1), 24'h00A0A0};
            bus.req_b[32*i +: 32] = 32'(i);
        end
        bus.req_valid = '1;
        z_result      = 32'h00000055;
        exp_ops       = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = k % NREQ;
`endif
            waitResponse(60, cyc, ok);
            checkOutput("rr_timeout", 32'(ok), 32'h1);
            checkOutput("rr_owner", 32'(owner), 32'(exp_owner));
            checkOutput("rr_rsp_valid", 32'(bus.rsp_valid), 32'(NREQ'(1) << exp_owner));
            checkOutput("rr_a_seen", a_seen, {8'(exp_owner + 1), 24'h00A0A0});
            checkOutput("rr_b_seen", b_seen, 32'(exp_owner));
            @(negedge clk);
            exp_ops++;
        end
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("rr_op_count", 32'(op_count), 32'(exp_ops));
        checkOutput("rr_idle", 32'(busy), 32'h0);

        // Back-pressure in RESP: only rsp_ready[owner] may complete the response.
        $display("[TB] response stall");
        @(negedge clk);
        bus.rsp_ready        = 4'b1011;
        z_result             = 32'h12345678;
        bus.req_a[64 +: 32]  = 32'hAAAA0000;
        bus.req_b[64 +: 32]  = 32'h00005555;
        bus.req_valid        = 4'b0100;
        #1;
        checkOutput("stall_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1011;
        waitResponse(60, cyc, ok);
        checkOutput("stall_timeout", 32'(ok), 32'h1);
        checkOutput("stall_first_valid", 32'(bus.rsp_valid), 32'h4);
        held_z = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'h4);
            checkOutput("stall_rsp_z", bus.rsp_z, held_z);
            checkOutput("stall_req_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("stall_strobes", 32'({add_a_stb, add_b_stb}), 32'h0);
            checkOutput("stall_op_count", 32'(op_count), 32'(exp_ops));
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        @(negedge clk);
        exp_ops++;
        checkOutput("stall_done_count", 32'(op_count), 32'(exp_ops));
        checkOutput("stall_done_valid", 32'(bus.rsp_valid), 32'h0);

        // Reset while waiting on a slow adder result aborts the operation.
        $display("[TB] reset in WAIT_Z");
        z_lat = 20;
        @(negedge clk);
        z_result             = 32'hDEADBEEF;
        bus.req_a[96 +: 32]  = 32'h00000003;
        bus.req_b[96 +: 32]  = 32'h00000004;
        bus.req_valid        = 4'b1000;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (add_z_ack) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("waitz_reached", 32'(ok), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("abort_z_ack", 32'(add_z_ack), 32'h0);
        checkOutput("abort_op_count", 32'(op_count), 32'h0);
        exp_ops = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        z_lat = 0;
        applyStimulus(1, 32'h00000010, 32'h00000020, 32'h0BADF00D, lat);
        checkOutput("after_abort_a", a_seen, 32'h00000010);

        // Counter wrap: preload near the top, then two more completions.
        $display("[TB] op_count wrap");
        @(negedge clk);
        force dut.op_count = 16'hFFFE;
        @(negedge clk);
        release dut.op_count;
        exp_ops = 16'hFFFE;
        applyStimulus(2, 32'h1, 32'h2, 32'h3, lat);
        checkOutput("count_ffff", 32'(op_count), 32'h0000FFFF);
        applyStimulus(3, 32'h4, 32'h5, 32'h9, lat);
        checkOutput("count_wrap", 32'(op_count), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IDXW, default 2, owner index width, equal to clog2(NREQ).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  32*NREQ  operand A; slice i is bits [32i+31:32i].
REQ-007 SHALL have port req_b  input  32*NREQ  operand B, same slicing as req_a.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot accept; transfer occurs on req_valid[i] & req_ready[i].
REQ-009 SHALL have port rsp_valid  output  NREQ  one-hot result valid.
REQ-010 SHALL have port rsp_z  output  32  result, shared by all requesters.
REQ-011 SHALL have port rsp_ready  input  NREQ  per-requester result accept.
REQ-012 SHALL have ports add_a / add_a_stb / add_a_ack, output 32 / output 1 / input 1, operand-A handshake to the shared adder.
REQ-013 SHALL have ports add_b / add_b_stb / add_b_ack, output 32 / output 1 / input 1, operand-B handshake.
REQ-014 SHALL have ports add_z / add_z_stb / add_z_ack, input 32 / input 1 / output 1, result handshake.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port owner  output  IDXW  index of the requester being served; holds the last value while IDLE.
REQ-017 SHALL have port op_count  output  16  number of completed responses.

Function
REQ-018 SHALL implement the FSM IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESP -> IDLE; no other transitions except reset.
REQ-019 IDLE: when any req_valid bit is set, SHALL drive req_ready high, combinationally, only for the winner (REQ-027), latch that requester's A, B and index, and enter SEND_A next cycle.
REQ-020 IDLE with req_valid = 0: req_ready SHALL be 0 and state SHALL hold; a request dropped before acceptance is simply not served.
REQ-021 SEND_A: SHALL drive add_a_stb = 1 with add_a = latched A; on add_a_stb & add_a_ack SHALL deassert add_a_stb next cycle and go to SEND_B.
REQ-022 SEND_B: SHALL behave as SEND_A, using add_b, and go to WAIT_Z.
REQ-023 WAIT_Z: SHALL drive add_z_ack = 1; on add_z_stb & add_z_ack SHALL latch add_z into rsp_z and go to RESP.
REQ-024 RESP: SHALL drive rsp_valid[owner] = 1 with rsp_z stable; on rsp_ready[owner] SHALL increment op_count (0xFFFF wraps to 0x0000) and return to IDLE.
REQ-025 Only one operation SHALL be in flight; no req_ready is asserted outside IDLE, and back-pressure in any state stalls indefinitely with all outputs held.
REQ-026 Each adder-side strobe SHALL be asserted only in its own state; an ack arriving before the strobe SHALL be ignored.
REQ-027 Arbitration SHALL be round-robin: search begins at pointer ptr, and on acceptance ptr <= (winner+1) mod NREQ.
REQ-028 Minimum latency from acceptance to rsp_valid SHALL be 3 cycles plus the adder's internal latency.

Reset
REQ-029 rst SHALL asynchronously force state = IDLE, ptr = 0, owner = 0, op_count = 0, and all strobes, acks, req_ready, rsp_valid and busy = 0, with rsp_z = 0.
REQ-030 Reset during any non-IDLE state SHALL abort the operation with no response; the same rst SHALL also reset the adder.

Configuration
REQ-031 With ADDER_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index wins, and ptr SHALL be unused and held at 0; without it, round-robin per REQ-027 SHALL apply.

Verification
REQ-032 Single request: req 0, A = 0x3F800000, B = 0x40000000 -> add_a/add_b presented in order, rsp_valid[0] with rsp_z = 0x40400000, op_count = 1.
REQ-033 All four req_valid held high from reset -> owners served in order 0,1,2,3,0; with ADDER_ARB_FIXED_PRIO_EN, 0,0,0,... with no other index served.
REQ-034 rsp_ready[owner] low for 10 cycles in RESP -> rsp_valid and rsp_z held, req_ready = 0 throughout, no new adder strobes.
REQ-035 rst asserted in WAIT_Z -> same-cycle return to IDLE with busy = 0 and rsp_valid = 0; next request is served normally.
REQ-036 op_count preloaded via 65535 completions, then one more completion -> op_count = 0x0000.
